// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: walks the frame in raster order, looks each pixel up through
// the tilemap and pattern RAMs and pushes it into the background FIFO. Scroll support is
// compiled in when BG_SCROLL_EN is defined.

module bg_tile_fetcher #(
    parameter int H_MAX  = 640,
    parameter int V_MAX  = 480,
    parameter int TIDX_W = 8,
    parameter int PIX_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [9:0]        scroll_x,
    input  logic [8:0]        scroll_y,
    output logic [12:0]       map_addr,
    input  logic [TIDX_W-1:0] map_data,
    output logic [TIDX_W+5:0] pat_addr,
    input  logic [PIX_W-1:0]  pat_data,
    output logic [PIX_W-1:0]  fifo_wdata,
    output logic              fifo_wr,
    input  logic              fifo_full,
    input  logic              fifo_almost_full,
    output logic              frame_done,
    output logic              overflow
);

    localparam logic [12:0] TILES_X = 13'(H_MAX / 8);
    localparam logic [9:0]  X_LAST  = 10'(H_MAX - 1);
    localparam logic [8:0]  Y_LAST  = 9'(V_MAX - 1);

    logic [9:0]        gen_x_q, gen_x_d;
    logic [8:0]        gen_y_q, gen_y_d;
    logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic              last1_q, last1_d, last2_q, last2_d, last3_q, last3_d, last4_q, last4_d;
    logic [5:0]        fine1_q, fine1_d, fine2_q, fine2_d;
    logic [12:0]       map_addr_q, map_addr_d;
    logic [TIDX_W+5:0] pat_addr_q, pat_addr_d;
    logic [PIX_W-1:0]  fifo_wdata_q, fifo_wdata_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q, overflow_d;

    logic              issue, first_pix, last_pix;
    logic [9:0]        wx;
    logic [8:0]        wy;

`ifdef BG_SCROLL_EN
    logic [9:0]  sx_q, sx_d, sx_in, sx_eff;
    logic [8:0]  sy_q, sy_d, sy_in, sy_eff;
    logic [10:0] wx_sum;
    logic [9:0]  wy_sum;
`else
    logic        unused_scroll;
    assign unused_scroll = ^{scroll_x, scroll_y};
`endif

    always_comb begin
        issue     = enable & ~fifo_almost_full;
        first_pix = (gen_x_q == 10'd0) && (gen_y_q == 9'd0);
        last_pix  = (gen_x_q == X_LAST) && (gen_y_q == Y_LAST);

`ifdef BG_SCROLL_EN
        // Pixel (0,0) already uses the scroll being latched for its frame.
        sx_in  = (scroll_x >= 10'(H_MAX)) ? scroll_x - 10'(H_MAX) : scroll_x;
        sy_in  = (scroll_y >= 9'(V_MAX)) ? scroll_y - 9'(V_MAX) : scroll_y;
        sx_eff = first_pix ? sx_in : sx_q;
        sy_eff = first_pix ? sy_in : sy_q;
        wx_sum = {1'b0, gen_x_q} + {1'b0, sx_eff};
        wy_sum = {1'b0, gen_y_q} + {1'b0, sy_eff};
        wx     = (wx_sum >= 11'(H_MAX)) ? 10'(wx_sum - 11'(H_MAX)) : wx_sum[9:0];
        wy     = (wy_sum >= 10'(V_MAX)) ? 9'(wy_sum - 10'(V_MAX)) : wy_sum[8:0];
        sx_d   = (issue && first_pix) ? sx_in : sx_q;
        sy_d   = (issue && first_pix) ? sy_in : sy_q;
`else
        wx = gen_x_q;
        wy = gen_y_q;
`endif

        gen_x_d = gen_x_q;
        gen_y_d = gen_y_q;
        if (issue) begin
            if (gen_x_q == X_LAST) begin
                gen_x_d = 10'd0;
                gen_y_d = (gen_y_q == Y_LAST) ? 9'd0 : gen_y_q + 9'd1;
            end else begin
                gen_x_d = gen_x_q + 10'd1;
            end
        end

        v1_d       = issue;
        last1_d    = issue & last_pix;
        fine1_d    = issue ? {wy[2:0], wx[2:0]} : fine1_q;
        map_addr_d = issue ? 13'(wy[8:3]) * TILES_X + 13'(wx[9:3]) : map_addr_q;

        v2_d       = v1_q;
        last2_d    = last1_q;
        fine2_d    = fine1_q;

        v3_d       = v2_q;
        last3_d    = last2_q;
        pat_addr_d = v2_q ? {map_data, fine2_q} : pat_addr_q;

        v4_d       = v3_q;
        last4_d    = last3_q;

        fifo_wr_d    = v4_q & ~fifo_full;
        fifo_wdata_d = v4_q ? pat_data : fifo_wdata_q;
        frame_done_d = v4_q & last4_q;
        overflow_d   = overflow_q | (v4_q & fifo_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_x_q      <= '0;
            gen_y_q      <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            v4_q         <= 1'b0;
            last1_q      <= 1'b0;
            last2_q      <= 1'b0;
            last3_q      <= 1'b0;
            last4_q      <= 1'b0;
            fine1_q      <= '0;
            fine2_q      <= '0;
            map_addr_q   <= '0;
            pat_addr_q   <= '0;
            fifo_wdata_q <= '0;
            fifo_wr_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef BG_SCROLL_EN
            sx_q         <= '0;
            sy_q         <= '0;
`endif
        end else begin
            gen_x_q      <= gen_x_d;
            gen_y_q      <= gen_y_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            v3_q         <= v3_d;
            v4_q         <= v4_d;
            last1_q      <= last1_d;
            last2_q      <= last2_d;
            last3_q      <= last3_d;
            last4_q      <= last4_d;
            fine1_q      <= fine1_d;
            fine2_q      <= fine2_d;
            map_addr_q   <= map_addr_d;
            pat_addr_q   <= pat_addr_d;
            fifo_wdata_q <= fifo_wdata_d;
            fifo_wr_q    <= fifo_wr_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
`ifdef BG_SCROLL_EN
            sx_q         <= sx_d;
            sy_q         <= sy_d;
`endif
        end
    end

    assign map_addr   = map_addr_q;
    assign pat_addr   = pat_addr_q;
    assign fifo_wdata = fifo_wdata_q;
    assign fifo_wr    = fifo_wr_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Scoreboard bench for bg_tile_fetcher on a reduced 64x16 frame, with RAM and FIFO models.
// Expectations follow BG_SCROLL_EN the same way the design does.

module tb_bg_tile_fetcher;

    localparam int H      = 64;
    localparam int V      = 16;
    localparam int FDEPTH = 16;

`ifdef BG_SCROLL_EN
    localparam int E00 = 15, E40 = 8, E04 = 7;
`else
    localparam int E00 = 0, E40 = 0, E04 = 0;
`endif

    logic        clk, rst_n, enable;
    logic [9:0]  scroll_x;
    logic [8:0]  scroll_y;
    logic [12:0] map_addr;
    logic [7:0]  map_data;
    logic [13:0] pat_addr;
    logic [8:0]  pat_data, fifo_wdata;
    logic        fifo_wr, fifo_full, fifo_almost_full, frame_done, overflow;

    logic [7:0]  tmap [0:8191];
    logic [8:0]  pat  [0:16383];

    int          fcount;
    logic        force_full, drain_mode;

    typedef struct packed {
        logic [8:0] pix;
        logic       last;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_fd, wr_cnt, nwr_frame;
    logic [8:0]  wr_log [0:79];
    logic        pend;
    logic [12:0] exp_ma;

    bg_tile_fetcher #(.H_MAX(H), .V_MAX(V), .TIDX_W(8), .PIX_W(9)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .scroll_x         (scroll_x),
        .scroll_y         (scroll_y),
        .map_addr         (map_addr),
        .map_data         (map_data),
        .pat_addr         (pat_addr),
        .pat_data         (pat_data),
        .fifo_wdata       (fifo_wdata),
        .fifo_wr          (fifo_wr),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .frame_done       (frame_done),
        .overflow         (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) map_data <= tmap[map_addr];
    always @(posedge clk) pat_data <= pat[pat_addr];

    assign fifo_almost_full = (FDEPTH - fcount) <= 5;
    assign fifo_full        = force_full || (fcount >= FDEPTH);

    initial begin : fifo_model
        int rd;
        fcount = 0;
        forever begin
            @(posedge clk);
            rd = (fcount > 0 && (drain_mode || $urandom_range(0, 1) == 1)) ? 1 : 0;
            if (!rst_n) fcount <= 0;
            else        fcount <= fcount + (fifo_wr ? 1 : 0) - rd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void ref_pixel(input int x, input int y, input int sx, input int sy,
                                      output int ma, output int pix);
        int wx, wy, pa;
        wx = x + sx;
        if (wx >= H) wx -= H;
        wy = y + sy;
        if (wy >= V) wy -= V;
        ma  = (wy / 8) * (H / 8) + wx / 8;
        pa  = int'(tmap[ma]) * 64 + (wy % 8) * 8 + (wx % 8);
        pix = int'(pat[pa]);
    endfunction

    // Reference raster: one expected entry per issued pixel, scroll latched at (0,0).
    initial begin : model
        int mx, my, msx, msy, ma, pix;
        mx = 0; my = 0; msx = 0; msy = 0;
        pend = 1'b0;
        exp_ma = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mx = 0; my = 0; msx = 0; msy = 0;
                sb_q.delete();
                pend = 1'b0;
            end else if (enable && !fifo_almost_full) begin
                if (mx == 0 && my == 0) begin
`ifdef BG_SCROLL_EN
                    msx = (int'(scroll_x) >= H) ? int'(scroll_x) - H : int'(scroll_x);
                    msy = (int'(scroll_y) >= V) ? int'(scroll_y) - V : int'(scroll_y);
`else
                    msx = 0;
                    msy = 0;
`endif
                end
                ref_pixel(mx, my, msx, msy, ma, pix);
                exp_ma = 13'(ma);
                pend   = 1'b1;
                sb_q.push_back('{pix: 9'(pix), last: (mx == H - 1 && my == V - 1)});
                if (mx == H - 1) begin
                    mx = 0;
                    my = (my == V - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        n_fd = 0; wr_cnt = 0; nwr_frame = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_cnt = 0;
                nwr_frame = 0;
            end else begin
                if (pend) check("map_addr", 32'(map_addr), 32'(exp_ma));
                if (frame_done) n_fd++;
                if (fifo_wr) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write actual=%0d required=no_write", fifo_wdata);
                    end else begin
                        e = sb_q.pop_front();
                        check("fifo_wdata", 32'(fifo_wdata), 32'(e.pix));
                        check("frame_done", 32'(frame_done), 32'(e.last));
                        if (wr_cnt < 80) wr_log[wr_cnt] = fifo_wdata;
                        wr_cnt++;
                        nwr_frame++;
                        if (e.last) begin
                            check("writes_per_frame", 32'(nwr_frame), 32'(H * V));
                            nwr_frame = 0;
                        end
                    end
                end else if (frame_done) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_done_without_write actual=1 required=0");
                end
            end
        end
    end

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        int lat;
        for (int i = 0; i < 8192; i++) tmap[i] = 8'((i * 5 + 3) & 255);
        for (int a = 0; a < 16384; a++) pat[a] = 9'(((a & 63) + 64 * ((a >> 6) ^ 3)) & 511);
        rst_n = 1'b0; enable = 1'b0; force_full = 1'b0; drain_mode = 1'b1;
        scroll_x = '0; scroll_y = '0;

        repeat (3) @(negedge clk);
        check("rst_map_addr",   32'(map_addr),   0);
        check("rst_pat_addr",   32'(pat_addr),   0);
        check("rst_fifo_wdata", 32'(fifo_wdata), 0);
        check("rst_fifo_wr",    32'(fifo_wr),    0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overflow",   32'(overflow),   0);
        rst_n = 1'b1;

        // Full frame at one pixel per cycle.
        @(negedge clk);
        enable = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (fifo_wr) begin
                lat = k;
                break;
            end
        end
        check("first_wr_latency", 32'(lat), 5);
        repeat (1100) @(negedge clk);
        check("frame_done_pulses", 32'(n_fd), 1);
        for (int i = 0; i < 8; i++) check("ramp_row0", 32'(wr_log[i]), 32'(i));
        for (int i = 0; i < 8; i++) check("ramp_row1", 32'(wr_log[H + i]), 32'(8 + i));
        enable = 1'b0;
        repeat (8) @(negedge clk);

        // Scroll wrap at the frame corner.
        rst_n = 1'b0;
        @(negedge clk);
        scroll_x = 10'd60; scroll_y = 9'd12;
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("scroll_map_0_0", 32'(map_addr), 32'(E00));
        repeat (4) @(negedge clk);
        check("scroll_map_4_0", 32'(map_addr), 32'(E40));
        repeat (252) @(negedge clk);
        check("scroll_map_0_4", 32'(map_addr), 32'(E04));

        // Random back-pressure and enable, with mid-frame scroll changes.
        drain_mode = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 7) != 0);
            if (c == 400)  begin scroll_x = 10'd100; scroll_y = 9'd5;  end
            if (c == 2600) begin scroll_x = 10'd3;   scroll_y = 9'd20; end
        end
        drain_mode = 1'b1;
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check("no_overflow", 32'(overflow), 0);
        check("sb_drained", 32'(sb_q.size()), 0);

        // Forced full drops writes and sets the sticky overflow.
        scroll_x = '0; scroll_y = '0;
        pulse_reset();
        enable = 1'b1;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        force_full = 1'b1;
        repeat (8) @(negedge clk);
        check("overflow_set", 32'(overflow), 1);
        force_full = 1'b0;
        repeat (3) @(negedge clk);
        check("overflow_sticky", 32'(overflow), 1);
        sb_q.delete();
        enable = 1'b1;
        repeat (10) @(negedge clk);
        check("overflow_held", 32'(overflow), 1);

        // Asynchronous reset mid-frame.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_fifo_wr",  32'(fifo_wr),  0);
        check("async_rst_overflow", 32'(overflow), 0);
        check("async_rst_map_addr", 32'(map_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_map_addr", 32'(map_addr), 0);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("sb_final_drained", 32'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bg_tile_fetcher.md
# bg_tile_fetcher

Producer side of the background pixel FIFO. It walks a 640x480 frame in raster order and looks up each pixel through an 80x60 tilemap of 8x8 tiles, with an optional frame-latched scroll offset. Each pixel is fetched through a two-RAM read pipeline and pushed into the background FIFO, whose read side is drained by the pixel counter and compositor. Back-pressure comes from the FIFO's almost-full flag, so the FIFO never overflows.

## Interface
Parameters:
- H_MAX, 640: active pixels per line.
- V_MAX, 480: active lines per frame.
- TIDX_W, 8: tile index width.
- PIX_W, 9: pixel width (RGB333).

Ports (clock and reset first):
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  issue permission; low stops new fetches, in-flight fetches still complete.
- scroll_x  in  10  horizontal scroll, latched at frame start.
- scroll_y  in  9  vertical scroll, latched at frame start.
- map_addr  out  13  tilemap RAM address, registered, 0..4799.
- map_data  in  TIDX_W  tilemap RAM data, one cycle after map_addr.
- pat_addr  out  TIDX_W+6  pattern RAM address {tile, py[2:0], px[2:0]}, registered.
- pat_data  in  PIX_W  pattern RAM data, one cycle after pat_addr.
- fifo_wdata  out  PIX_W  pixel to the FIFO, registered.
- fifo_wr  out  1  FIFO write strobe, registered.
- fifo_full  in  1  FIFO full.
- fifo_almost_full  in  1  asserted when free entries ≤ 5.
- frame_done  out  1  one-cycle pulse in the cycle that pixel (639,479) is written.
- overflow  out  1  sticky flag; set when a write is dropped because fifo_full is high.

## Operation
- Issue condition: `issue = enable & ~fifo_almost_full`. It is evaluated every cycle, and at most one pixel is issued per cycle.
- Generator counters:
  - gen_x is 10 bits and gen_y is 9 bits; both reset to 0.
  - On issue, gen_x increments. At 639 it wraps to 0 and gen_y increments.
  - At (639,479) both counters wrap to 0.
- Scroll latch:
  - When issuing pixel (0,0), sx <= scroll_x and sy <= scroll_y.
  - If a value is ≥ H_MAX (resp. V_MAX), subtract it once.
  - sx and sy hold for the whole frame.
- Wrapped coordinates:
  - wx = gen_x + sx; if wx ≥ 640, subtract 640 (11-bit sum).
  - wy = gen_y + sy; if wy ≥ 480, subtract 480 (10-bit sum).
- Addresses:
  - map_addr = (wy>>3)*80 + (wx>>3).
  - pat_addr = {map_data, wy[2:0], wx[2:0]}.
- Pipeline control: a valid bit travels with each stage. wx[2:0] and wy[2:0] are carried alongside the stages until pat_addr is formed.
- FIFO write guard: a write that coincides with fifo_full high is dropped, and overflow is set. overflow clears only on reset.
- frame_done is driven from the stage-4 valid bit qualified by a last-pixel tag, not from the generator counters.

## Timing
- Issue in cycle N gives:
  - map_addr valid in N+1;
  - map_data valid in N+2, and pat_addr registered, valid in N+3;
  - pat_data valid in N+4;
  - fifo_wr high with fifo_wdata in N+5.
- Issue-to-write latency is therefore 5 cycles.
- Up to 5 pixels can be in flight. This is the reason almost_full must assert at ≤ 5 free entries, which guarantees no overflow.
- Throughput is 1 pixel per cycle while issue stays high.
- Stall behaviour:
  - Deasserting enable or raising almost_full stops issue in that same cycle.
  - The pipeline drains in ≤ 5 cycles.
  - Stalls never reorder pixels and never duplicate them.
- Reset values: map_addr = 0, pat_addr = 0, fifo_wdata = 0, fifo_wr = 0, frame_done = 0, overflow = 0. All valid bits, counters, sx and sy are also 0.
- Asynchronous reset mid-frame: in-flight pixels are discarded, and the next issue starts at pixel (0,0).
- Simultaneous last-pixel issue and scroll change: the new scroll applies from the next (0,0) issue only.

## Configuration
- BG_SCROLL_EN:
  - Defined: scroll latch and wrap arithmetic are included as described above.
  - Undefined: scroll_x and scroll_y are ignored, and sx = sy = 0 permanently. map_addr is computed directly from gen_x and gen_y with no adders. Latency stays 5 cycles.

## Test plan
- Reset, then hold enable=1 and almost_full=0. Expect the first fifo_wr exactly 5 cycles after the first issue, and 307200 writes per frame. frame_done pulses once, in the same cycle that pixel (639,479) is written.
- Tilemap word 0 = 3, pattern[3] = ramp with pixel = px + 8*py. Expect the first 8 writes to be 0..7, and writes 641..648 to be 8..15.
- Toggle almost_full randomly with a model FIFO of depth 16 that asserts at ≤ 5 free entries. Expect overflow to stay 0 and the pixel order to match the reference raster.
- With BG_SCROLL_EN defined, scroll_x=636 and scroll_y=476:
  - pixel (0,0) reads map_addr 59*80+79 = 4799;
  - pixel (4,0) reads map_addr 59*80 = 4720;
  - pixel (0,4) reads map_addr 79.
- Change scroll mid-frame. Expect no effect until the next frame's first write.
- Force fifo_full=1 while the pipeline is full. Expect overflow to go high and stay high until rst_n. Assert rst_n mid-frame and expect fifo_wr=0 immediately, with the restart at map_addr 0.
